nand_serial_adder: RTL and testbench

- Multi-cycle, digit-serial two's-complement adder/subtractor built from NAND full-adder cells.
- Processes WIDTH-bit operands DIGIT bits per clock. Carry is held in a register between steps.
- Sits between operand producers and ALU result consumers. Uses a valid/ready handshake on both sides.
- Trades latency for area against a full-width ripple adder.

---
 rtl/nand_adder_pkg.sv | 28 ++
 rtl/nand_serial_adder_if.sv | 29 ++
 rtl/nand_digit_adder.sv | 37 +++
 rtl/nand_serial_adder.sv | 115 +++++++++++
 tb/tb_nand_serial_adder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nand_adder_pkg.sv
// Shared definitions for the digit-serial NAND adder: FSM state encoding,
// the NAND primitive used by the full-adder cells, and a clog2 helper.
package nand_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two-input NAND, the only gate used inside the full-adder cell.
  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nand_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The master side produces operands and consumes results; the slave is the adder.
interface nand_serial_adder_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             subtract;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, operand_a, operand_b, carry_in, subtract, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, operand_a, operand_b, carry_in, subtract, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/nand_digit_adder.sv
// Combinational DIGIT-bit ripple adder made of 9-NAND full-adder cells.
// c_msb_in exposes the carry entering the top bit so the caller can derive
// signed overflow as (carry into MSB) xor (carry out of MSB).
module nand_digit_adder
  import nand_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic n1_s, n2_s, n3_s, x_s, n5_s, n6_s, n7_s;
    assign n1_s       = nand2(a[i], b[i]);
    assign n2_s       = nand2(a[i], n1_s);
    assign n3_s       = nand2(b[i], n1_s);
    assign x_s        = nand2(n2_s, n3_s);     // a ^ b
    assign n5_s       = nand2(x_s, c_s[i]);
    assign n6_s       = nand2(x_s, n5_s);
    assign n7_s       = nand2(c_s[i], n5_s);
    assign s[i]       = nand2(n6_s, n7_s);     // a ^ b ^ cin
    assign c_s[i + 1] = nand2(n1_s, n5_s);     // ab | cin(a ^ b)
  end

  assign cout     = c_s[DIGIT];
  assign c_msb_in = c_s[DIGIT-1];

endmodule

// File: rtl/nand_serial_adder.sv
// Digit-serial two's-complement adder/subtractor. Operands are captured in
// IDLE, summed DIGIT bits per clock in RUN with the carry held in a register,
// and the result is held in DONE until the consumer takes it.
module nand_serial_adder
  import nand_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  nand_serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("nand_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t             state_r;
  logic [CNT_W-1:0]   step_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_out_r;
  logic               overflow_r;

  logic [31:0]        shamt_s;
  logic [DIGIT-1:0]   a_dig_s;
  logic [DIGIT-1:0]   b_dig_s;
  logic [DIGIT-1:0]   s_dig_s;
  logic [WIDTH-1:0]   sum_ins_s;
  logic               cout_s;
  logic               c_msb_s;

  // Select the operand digit for the current step and place the digit sum back at its position.
  always_comb begin
    shamt_s   = 32'(step_r) * 32'(DIGIT);
    a_dig_s   = DIGIT'(a_r >> shamt_s);
    b_dig_s   = DIGIT'(b_r >> shamt_s);
    sum_ins_s = WIDTH'(s_dig_s) << shamt_s;
  end

  nand_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a        (a_dig_s),
    .b        (b_dig_s),
    .cin      (carry_r),
    .s        (s_dig_s),
    .cout     (cout_s),
    .c_msb_in (c_msb_s)
  );

  // Control FSM with operand, carry, step and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      step_r      <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.operand_a;
            b_r     <= bus.subtract ? ~bus.operand_b : bus.operand_b;
            carry_r <= bus.subtract ? 1'b1 : bus.carry_in;
            sum_r   <= '0;
            step_r  <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          // sum was cleared at capture, so OR-ing the digit in is a plain write
          sum_r   <= sum_r | sum_ins_s;
          carry_r <= cout_s;
          if (step_r == LAST_STEP) begin
            carry_out_r <= cout_s;
            // operands of equal sign with a differing result sign <=> carry into MSB != carry out
            overflow_r  <= c_msb_s ^ cout_s;
            step_r      <= '0;
            state_r     <= DONE;
          end else begin
            step_r <= step_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          step_r  <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_nand_serial_adder.sv
// Bench for nand_serial_adder: a WIDTH=32/DIGIT=4 instance exercised with a
// vector table, random operands against an arithmetic reference model and
// hand-written backpressure/reset sequences, plus a WIDTH=32/DIGIT=32 instance.
module tb_nand_serial_adder;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  nand_serial_adder_if #(.WIDTH(32)) bus4 ();
  nand_serial_adder_if #(.WIDTH(32)) bus32 ();

  nand_serial_adder #(.WIDTH(32), .DIGIT(4)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  nand_serial_adder #(.WIDTH(32), .DIGIT(32)) dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: true integer arithmetic; returns {overflow, carry_out, sum}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint sa, sb, sr;
    logic [63:0] ua;
    logic [31:0] s;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      sr = sa - sb;
      s  = a - b;
      co = (a >= b);
    end else begin
      sr = sa + sb + (cin ? 64'sd1 : 64'sd0);
      ua = {32'd0, a} + {32'd0, b} + 64'(cin);
      s  = ua[31:0];
      co = (ua > 64'h0000_0000_FFFF_FFFF);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, co, s};
  endfunction

  task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    check1("in_ready_before_accept", bus4.in_ready, 1'b1);
    bus4.operand_a = a;
    bus4.operand_b = b;
    bus4.carry_in  = cin;
    bus4.subtract  = sub;
    bus4.in_valid  = 1'b1;
    @(negedge clock);
    bus4.in_valid  = 1'b0;
    bus4.operand_a = $urandom;
    bus4.operand_b = $urandom;
    bus4.carry_in  = 1'($urandom);
    bus4.subtract  = 1'($urandom);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic release4(input string nm);
    bus4.out_ready = 1'b1;
    @(negedge clock);
    bus4.out_ready = 1'b0;
    check1({nm, "_out_valid_after_take"}, bus4.out_valid, 1'b0);
    check1({nm, "_in_ready_after_take"}, bus4.in_ready, 1'b1);
  endtask

  task automatic txn4(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic [31:0] es,
                      input logic eco, input logic eov, input int hold);
    int n;
    start4(a, b, cin, sub);
    check1({nm, "_in_ready_busy"}, bus4.in_ready, 1'b0);
    wait_done4(n);
    check_int({nm, "_latency"}, n, 8);
    check32({nm, "_sum"}, bus4.sum, es);
    check1({nm, "_carry_out"}, bus4.carry_out, eco);
    check1({nm, "_overflow"}, bus4.overflow, eov);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check1({nm, "_held_valid"}, bus4.out_valid, 1'b1);
      check32({nm, "_held_sum"}, bus4.sum, es);
    end
    release4(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [33:0] exp;
    logic [31:0] ra, rb, keep_sum;
    logic rcin, rsub;
    int n, last_acc;
    logic [33:0] q[$];

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    reset_n = 1'b0;
    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;
    bus4.operand_a = 32'h0; bus4.operand_b = 32'h0; bus4.carry_in = 1'b0; bus4.subtract = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.operand_a = 32'h0; bus32.operand_b = 32'h0; bus32.carry_in = 1'b0; bus32.subtract = 1'b0;

    @(negedge clock);
    check1("reset_in_ready", bus4.in_ready, 1'b1);
    check1("reset_out_valid", bus4.out_valid, 1'b0);
    check32("reset_sum", bus4.sum, 32'h0);
    check1("reset_carry_out", bus4.carry_out, 1'b0);
    check1("reset_overflow", bus4.overflow, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      txn4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           vecs[i].sum, vecs[i].co, vecs[i].ov, i % 3);
    end

    // Random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      if (i % 6 == 0) ra = 32'h7FFF_FFFF;
      if (i % 6 == 1) ra = 32'h8000_0000;
      if (i % 6 == 2) rb = ra;
      exp = model(ra, rb, rcin, rsub);
      txn4($sformatf("rand%0d", i), ra, rb, rcin, rsub, exp[31:0], exp[32], exp[33],
           int'($urandom_range(0, 2)));
    end

    // Backpressure: result held, new operands ignored while out_ready is low
    start4(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done4(n);
    check_int("bp_latency", n, 8);
    check32("bp_sum", bus4.sum, 32'h0001_0000);
    for (int h = 0; h < 5; h++) begin
      bus4.in_valid  = 1'b1;
      bus4.operand_a = $urandom;
      bus4.operand_b = $urandom;
      bus4.subtract  = 1'($urandom);
      @(negedge clock);
      check32("bp_sum_held", bus4.sum, 32'h0001_0000);
      check1("bp_co_held", bus4.carry_out, 1'b0);
      check1("bp_ov_held", bus4.overflow, 1'b0);
      check1("bp_out_valid", bus4.out_valid, 1'b1);
      check1("bp_in_ready_low", bus4.in_ready, 1'b0);
    end
    bus4.in_valid = 1'b0;
    release4("bp");
    check32("bp_no_capture", bus4.sum, 32'h0001_0000);

    // Leave carry_out=1 registered, then abort a run with reset at step 3
    txn4("pre_reset", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    start4(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check32("rst_mid_sum", bus4.sum, 32'h0);
    check1("rst_mid_co", bus4.carry_out, 1'b0);
    check1("rst_mid_ov", bus4.overflow, 1'b0);
    check1("rst_mid_out_valid", bus4.out_valid, 1'b0);
    check1("rst_mid_in_ready", bus4.in_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    txn4("post_reset", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 0);

    // DIGIT == WIDTH instance: single-cycle latency
    check1("w32_in_ready", bus32.in_ready, 1'b1);
    bus32.operand_a = 32'h1234_5678;
    bus32.operand_b = 32'h1111_1111;
    bus32.carry_in  = 1'b1;
    bus32.subtract  = 1'b0;
    bus32.in_valid  = 1'b1;
    @(negedge clock);
    bus32.in_valid  = 1'b0;
    n = 0;
    while (bus32.out_valid !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check_int("w32_latency", n, 1);
    check32("w32_sum", bus32.sum, 32'h2345_678A);
    check1("w32_co", bus32.carry_out, 1'b0);
    check1("w32_ov", bus32.overflow, 1'b0);
    bus32.out_ready = 1'b1;
    @(negedge clock);
    check1("w32_in_ready_after", bus32.in_ready, 1'b1);

    // Back-to-back with out_ready tied high: one accept every third cycle
    bus32.in_valid = 1'b1;
    last_acc = -1;
    for (int c = 0; c < 16; c++) begin
      ra   = $urandom;
      rb   = $urandom;
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      bus32.operand_a = ra;
      bus32.operand_b = rb;
      bus32.carry_in  = rcin;
      bus32.subtract  = rsub;
      if (bus32.in_ready === 1'b1) begin
        if (last_acc >= 0) check_int("b2b_gap", c - last_acc, 3);
        last_acc = c;
        q.push_back(model(ra, rb, rcin, rsub));
      end
      if (bus32.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check1("b2b_unexpected_result", 1'b1, 1'b0);
        end else begin
          exp = q.pop_front();
          check32("b2b_sum", bus32.sum, exp[31:0]);
          check1("b2b_co", bus32.carry_out, exp[32]);
          check1("b2b_ov", bus32.overflow, exp[33]);
        end
      end
      @(negedge clock);
    end
    bus32.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus32.out_valid === 1'b1 && q.size() != 0) begin
        exp = q.pop_front();
        check32("b2b_drain_sum", bus32.sum, exp[31:0]);
      end
      @(negedge clock);
    end
    check_int("b2b_queue_empty", q.size(), 0);
    check_int("b2b_accepts_seen", (last_acc >= 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
